// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the FSM state encoding and the weight-to-credit rule.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest weight field the credit helper supports; callers zero-extend into it.
    localparam int MaxWeightW = 16;

    function automatic logic [MaxWeightW-1:0] weight_or_one(input logic [MaxWeightW-1:0] w);
        if (w == {MaxWeightW{1'b0}}) begin
            return {{(MaxWeightW-1){1'b0}}, 1'b1};
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start,
// wrapping past NumReq-1 back to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   start,
    output logic              found,
    output logic [IdxW-1:0]   idx,
    output logic [NumReq-1:0] onehot
);

    int pos_s;

    // Scan req in rotated order and keep the first hit.
    always_comb begin
        found = 1'b0;
        idx   = {IdxW{1'b0}};
        pos_s = 0;
        for (int k = 0; k < NumReq; k++) begin
            pos_s = (int'(start) + k) % NumReq;
            if (!found && req[pos_s]) begin
                found = 1'b1;
                idx   = IdxW'(pos_s);
            end else begin
                found = found;
            end
        end
    end

    // Decode the winning index into a one-hot vector.
    always_comb begin
        onehot = {NumReq{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            onehot[i] = found && (idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a grantee keeps its registered one-hot grant
// for up to weight[i] complete transactions, then priority rotates.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int WeightW = 4,
    parameter int IdxW    = $clog2(NumReq)
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NumReq-1:0]         req,
    input  logic [NumReq-1:0]         last,
    input  logic [NumReq*WeightW-1:0] weight,
    input  logic                      gnt_ready,
    output logic [NumReq-1:0]         grant,
    output logic                      grant_valid,
    output logic [IdxW-1:0]           grant_idx
);

    arb_state_t          state_r, state_n;
    logic [IdxW-1:0]     cur_r, cur_n;
    logic [IdxW-1:0]     ptr_r, ptr_n;
    logic [WeightW-1:0]  credit_r, credit_n;
    logic [NumReq-1:0]   grant_r, grant_n;

    logic                in_grant_s;
    logic                txn_end_s;
    logic                rel_quota_s;
    logic                rel_drop_s;
    logic                release_s;
    logic [IdxW-1:0]     cur_inc_s;
    logic [NumReq-1:0]   pick_req_s;
    logic [IdxW-1:0]     pick_start_s;
    logic                pick_found_s;
    logic [IdxW-1:0]     pick_idx_s;
    logic [NumReq-1:0]   pick_onehot_s;
    logic [IdxW-1:0]     load_idx_s;
    logic [WeightW-1:0]  load_credit_s;

    assign in_grant_s  = (state_r == GRANT);
    assign txn_end_s   = in_grant_s && gnt_ready && last[cur_r];
    assign rel_quota_s = txn_end_s && (credit_r == WeightW'(1));
    assign rel_drop_s  = in_grant_s && !req[cur_r];
    assign release_s   = rel_quota_s || rel_drop_s;
    assign cur_inc_s   = (cur_r == IdxW'(NumReq - 1)) ? {IdxW{1'b0}} : cur_r + IdxW'(1);

    // In GRANT the grant register is exactly onehot(cur), so it masks the current owner.
    assign pick_req_s   = in_grant_s ? (req & ~grant_r) : req;
    assign pick_start_s = in_grant_s ? cur_inc_s : ptr_r;

    rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req    (pick_req_s),
        .start  (pick_start_s),
        .found  (pick_found_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Credit is loaded for either a new winner or a re-grant of the current owner.
    assign load_idx_s    = pick_found_s ? pick_idx_s : cur_r;
    assign load_credit_s = WeightW'(weight_or_one(
                               MaxWeightW'(weight[load_idx_s*WeightW +: WeightW])));

    // Next-state, grant and credit bookkeeping.
    always_comb begin
        state_n  = state_r;
        cur_n    = cur_r;
        ptr_n    = ptr_r;
        credit_n = credit_r;
        grant_n  = grant_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_n  = GRANT;
                    cur_n    = pick_idx_s;
                    credit_n = load_credit_s;
                    grant_n  = pick_onehot_s;
                end else begin
                    grant_n  = {NumReq{1'b0}};
                end
            end
            GRANT: begin
                if (release_s) begin
                    ptr_n = cur_inc_s;
                    if (pick_found_s) begin
                        cur_n    = pick_idx_s;
                        credit_n = load_credit_s;
                        grant_n  = pick_onehot_s;
                    end else if (rel_quota_s && req[cur_r]) begin
                        credit_n = load_credit_s;
                    end else begin
                        state_n = IDLE;
                        grant_n = {NumReq{1'b0}};
                    end
                end else if (txn_end_s) begin
                    credit_n = credit_r - WeightW'(1);
                end else begin
                    credit_n = credit_r;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = {NumReq{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r  <= IDLE;
            cur_r    <= {IdxW{1'b0}};
            ptr_r    <= {IdxW{1'b0}};
            credit_r <= {WeightW{1'b0}};
            grant_r  <= {NumReq{1'b0}};
        end else begin
            state_r  <= state_n;
            cur_r    <= cur_n;
            ptr_r    <= ptr_n;
            credit_r <= credit_n;
            grant_r  <= grant_n;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = |grant_r;
    assign grant_idx   = cur_r;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (NumReq=4, WeightW=4).
module tb_wrr_arbiter;

    logic        clk;
    logic        rstN;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] weight;
    logic        gnt_ready;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_idx;

    int checks;
    int errors;

    wrr_arbiter #(
        .NumReq  (4),
        .WeightW (4)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req         (req),
        .last        (last),
        .weight      (weight),
        .gnt_ready   (gnt_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".valid"}, 32'(grant_valid), 32'(g != 4'b0000));
        check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [3:0] pat3 [8];
    logic [1:0] idx3 [8];

    initial begin
        checks = 0;
        errors = 0;
        pat3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        idx3 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};

        rstN      = 1'b0;
        req       = 4'b0000;
        last      = 4'b0000;
        weight    = 16'h1111;
        gnt_ready = 1'b0;
        step();
        step();
        rstN = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step();
            check_grant("idle", 4'b0000, 2'd0);
        end

        // Alternating grants, weight 1, no idle gap.
        req       = 4'b1010;
        last      = 4'b1111;
        gnt_ready = 1'b1;
        step(); check_grant("alt0", 4'b0010, 2'd1);
        step(); check_grant("alt1", 4'b1000, 2'd3);
        step(); check_grant("alt2", 4'b0010, 2'd1);
        step(); check_grant("alt3", 4'b1000, 2'd3);
        req  = 4'b0000;
        last = 4'b0000;
        step(); check_grant("alt_idle", 4'b0000, 2'd3);
        check("alt_ptr", 32'(dut.ptr_r), 32'd0);

        // Weighted: requester 0 gets three transactions per turn.
        weight[3:0] = 4'd3;
        weight[7:4] = 4'd1;
        req  = 4'b0011;
        last = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check_grant($sformatf("wrr%0d", i), pat3[i], idx3[i]);
        end
        req  = 4'b0000;
        last = 4'b0000;
        step(); check_grant("wrr_idle", 4'b0000, 2'd1);
        check("wrr_ptr", 32'(dut.ptr_r), 32'd2);

        // Abandoned request hands off to requester 3 back-to-back.
        req = 4'b1100;
        step(); check_grant("drop0", 4'b0100, 2'd2);
        step(); check_grant("drop1", 4'b0100, 2'd2);
        req = 4'b1000;
        step(); check_grant("drop2", 4'b1000, 2'd3);
        check("drop_ptr", 32'(dut.ptr_r), 32'd3);
        req = 4'b0000;
        step(); check_grant("drop_idle", 4'b0000, 2'd3);
        check("drop_ptr2", 32'(dut.ptr_r), 32'd0);

        // Weight 0 acts as 1; lone requester is re-granted continuously.
        weight[7:4] = 4'd0;
        req  = 4'b0010;
        last = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            check_grant($sformatf("solo%0d", i), 4'b0010, 2'd1);
            check($sformatf("solo_credit%0d", i), 32'(dut.credit_r), 32'd1);
        end
        check("solo_ptr", 32'(dut.ptr_r), 32'd2);
        gnt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_grant($sformatf("hold%0d", i), 4'b0010, 2'd1);
        end
        req  = 4'b0000;
        last = 4'b0000;
        step(); check_grant("solo_idle", 4'b0000, 2'd1);
        check("solo_ptr2", 32'(dut.ptr_r), 32'd2);

        // Credit is spent only on accepted last beats.
        weight[11:8] = 4'd3;
        req = 4'b0100;
        step(); check_grant("cr0", 4'b0100, 2'd2);
        check("cr_load", 32'(dut.credit_r), 32'd3);
        last = 4'b0100;
        step(); check("cr_noready0", 32'(dut.credit_r), 32'd3);
        step(); check("cr_noready1", 32'(dut.credit_r), 32'd3);
        gnt_ready = 1'b1;
        step(); check("cr_dec", 32'(dut.credit_r), 32'd2);
        check_grant("cr1", 4'b0100, 2'd2);

        // Reset mid-grant drops everything at the next edge.
        gnt_ready = 1'b0;
        last      = 4'b0000;
        rstN      = 1'b0;
        step(); check_grant("rst", 4'b0000, 2'd0);
        check("rst_ptr", 32'(dut.ptr_r), 32'd0);
        check("rst_credit", 32'(dut.credit_r), 32'd0);
        rstN        = 1'b1;
        weight[3:0] = 4'd15;
        req         = 4'b1111;
        step(); check_grant("post_rst", 4'b0001, 2'd0);
        check("max_credit", 32'(dut.credit_r), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
